// File: rtl/inv_pkg.sv
// ============================================================================
// Module   : inv_pkg
// Brief    : Shared types and constants for the matrix-inverse sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package inv_pkg;

   localparam int N_DEFAULT = 5;

   localparam logic [1:0] CMD_NOP   = 2'd0;
   localparam logic [1:0] CMD_SWAP  = 2'd1;
   localparam logic [1:0] CMD_SCALE = 2'd2;
   localparam logic [1:0] CMD_ELIM  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SEARCH = 3'd1,
      ST_SWAP   = 3'd2,
      ST_SCALE  = 3'd3,
      ST_EPROBE = 3'd4,
      ST_ELIM   = 3'd5,
      ST_FIN    = 3'd6
   } state_e;

endpackage

`default_nettype wire

// File: rtl/inverse_seq_ctrl_next_row.sv
// ============================================================================
// Module   : inv_next_row
// Brief    : Next row index after idx_i that skips the pivot row k_i; last_o
//            flags that no such row exists.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inv_next_row #(
   parameter int N    = 5,
   parameter int IDXW = $clog2(N)
) (
   input  logic [IDXW-1:0] idx_i,
   input  logic [IDXW-1:0] k_i,
   output logic [IDXW-1:0] next_o,
   output logic            last_o
);

   localparam logic [IDXW:0] LAST_ROW = (IDXW+1)'(N-1);

   logic [IDXW:0] w_step1;
   logic [IDXW:0] w_step2;

   always_comb begin
      w_step1 = {1'b0, idx_i} + (IDXW+1)'(1);
      w_step2 = (w_step1 == {1'b0, k_i}) ? w_step1 + (IDXW+1)'(1) : w_step1;
      last_o  = (w_step2 > LAST_ROW);
      next_o  = last_o ? idx_i : w_step2[IDXW-1:0];
   end

endmodule

`default_nettype wire

// File: rtl/inverse_seq_ctrl.sv
// ============================================================================
// Module   : inverse_seq_ctrl
// Brief    : Gauss-Jordan pivot sequencer issuing SWAP/SCALE/ELIM row commands.
//            Macro INV_SEQ_ELIM_SKIP_EN skips ELIM for rows already zero in k.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inverse_seq_ctrl
   import inv_pkg::*;
#(
   parameter int N    = N_DEFAULT,
   parameter int IDXW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            singular,
   output logic [IDXW-1:0] probe_row,
   output logic [IDXW-1:0] probe_col,
   input  logic            probe_zero,
   output logic            cmd_valid,
   input  logic            cmd_ready,
   output logic [1:0]      cmd_op,
   output logic [IDXW-1:0] cmd_prow,
   output logic [IDXW-1:0] cmd_trow
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N-1);

`ifdef INV_SEQ_ELIM_SKIP_EN
   localparam state_e ROW_ENTRY = ST_EPROBE;
`else
   localparam state_e ROW_ENTRY = ST_ELIM;
`endif

   state_e            state_q, state_d;
   logic [IDXW-1:0]   k_q, k_d;
   logic [IDXW-1:0]   r_q, r_d;
   logic [IDXW-1:0]   i_q, i_d;
   logic              singular_q, singular_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic [1:0]        cmd_op_q, cmd_op_d;
   logic [IDXW-1:0]   cmd_prow_q, cmd_prow_d;
   logic [IDXW-1:0]   cmd_trow_q, cmd_trow_d;
   logic [IDXW-1:0]   probe_row_q, probe_row_d;
   logic [IDXW-1:0]   probe_col_q, probe_col_d;

   logic              w_xfer;
   logic [IDXW-1:0]   w_first_row;
   logic [IDXW-1:0]   w_next_row;
   logic              w_next_last;
   state_e            w_adv_state;
   logic [IDXW-1:0]   w_adv_k, w_adv_r, w_adv_i;

   inv_next_row #(
      .N    (N),
      .IDXW (IDXW)
   ) u_next_row (
      .idx_i  (i_q),
      .k_i    (k_q),
      .next_o (w_next_row),
      .last_o (w_next_last)
   );

   assign w_xfer      = cmd_valid_q & cmd_ready;
   assign w_first_row = (k_q == '0) ? IDXW'(1) : '0;

   // Moving past row i: next non-pivot row, else next pivot column, else finish.
   always_comb begin
      w_adv_state = ROW_ENTRY;
      w_adv_i     = w_next_row;
      w_adv_k     = k_q;
      w_adv_r     = r_q;
      if (w_next_last) begin
         w_adv_i = i_q;
         if (k_q == LAST_IDX) begin
            w_adv_state = ST_FIN;
         end else begin
            w_adv_state = ST_SEARCH;
            w_adv_k     = k_q + IDXW'(1);
            w_adv_r     = k_q + IDXW'(1);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      r_d        = r_q;
      i_d        = i_q;
      singular_d = singular_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               singular_d = 1'b0;
               k_d        = '0;
               r_d        = '0;
               state_d    = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (!probe_zero) begin
               state_d = (r_q == k_q) ? ST_SCALE : ST_SWAP;
            end else if (r_q != LAST_IDX) begin
               r_d = r_q + IDXW'(1);
            end else begin
               singular_d = 1'b1;
               state_d    = ST_FIN;
            end
         end
         ST_SWAP: begin
            if (w_xfer) state_d = ST_SCALE;
         end
         ST_SCALE: begin
            if (w_xfer) begin
               i_d     = w_first_row;
               state_d = ROW_ENTRY;
            end
         end
         ST_EPROBE: begin
            if (probe_zero) begin
               state_d = w_adv_state;
               k_d     = w_adv_k;
               r_d     = w_adv_r;
               i_d     = w_adv_i;
            end else begin
               state_d = ST_ELIM;
            end
         end
         ST_ELIM: begin
            if (w_xfer) begin
               state_d = w_adv_state;
               k_d     = w_adv_k;
               r_d     = w_adv_r;
               i_d     = w_adv_i;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered from the next state; a transfer forces one idle
      // cycle on cmd_valid so commands never go back-to-back.
      busy_d      = state_d inside {ST_SEARCH, ST_SWAP, ST_SCALE, ST_EPROBE, ST_ELIM};
      done_d      = (state_d == ST_FIN);
      cmd_valid_d = (state_d inside {ST_SWAP, ST_SCALE, ST_ELIM}) && !w_xfer;

      cmd_op_d   = CMD_NOP;
      cmd_prow_d = cmd_prow_q;
      cmd_trow_d = cmd_trow_q;
      case (state_d)
         ST_SWAP: begin
            cmd_op_d   = CMD_SWAP;
            cmd_prow_d = k_d;
            cmd_trow_d = r_d;
         end
         ST_SCALE: begin
            cmd_op_d   = CMD_SCALE;
            cmd_prow_d = k_d;
            cmd_trow_d = k_d;
         end
         ST_ELIM: begin
            cmd_op_d   = CMD_ELIM;
            cmd_prow_d = k_d;
            cmd_trow_d = i_d;
         end
         default: ;
      endcase

      probe_row_d = probe_row_q;
      probe_col_d = probe_col_q;
      if (state_d == ST_SEARCH) begin
         probe_row_d = r_d;
         probe_col_d = k_d;
      end else if (state_d == ST_EPROBE) begin
         probe_row_d = i_d;
         probe_col_d = k_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         r_q         <= '0;
         i_q         <= '0;
         singular_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_op_q    <= CMD_NOP;
         cmd_prow_q  <= '0;
         cmd_trow_q  <= '0;
         probe_row_q <= '0;
         probe_col_q <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         r_q         <= r_d;
         i_q         <= i_d;
         singular_q  <= singular_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_op_q    <= cmd_op_d;
         cmd_prow_q  <= cmd_prow_d;
         cmd_trow_q  <= cmd_trow_d;
         probe_row_q <= probe_row_d;
         probe_col_q <= probe_col_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign singular  = singular_q;
   assign cmd_valid = cmd_valid_q;
   assign cmd_op    = cmd_op_q;
   assign cmd_prow  = cmd_prow_q;
   assign cmd_trow  = cmd_trow_q;
   assign probe_row = probe_row_q;
   assign probe_col = probe_col_q;

endmodule

`default_nettype wire
